// File: rtl/yolo_stream_pkg.sv
// Shared definitions for the TinyYOLOv3 feature-map stream blocks:
// vector geometry, the upsampler state encoding and a configuration check.
package yolo_stream_pkg;

    localparam int VEC_W  = 64;
    localparam int LANES  = 8;
    localparam int LANE_W = VEC_W / LANES;

    // Per-lane padding value (most negative int8) used by padding stages.
    localparam logic [VEC_W-1:0] PAD_VALUE = {LANES{8'h80}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } up_state_e;

    // A frame is runnable when every dimension is nonzero and one input
    // row (width x channel groups) fits in the row buffer.
    function automatic logic cfg_is_valid(
        input logic [15:0] width,
        input logic [15:0] height,
        input logic [15:0] ch_groups,
        input logic [31:0] row_vectors,
        input logic [31:0] max_vectors
    );
        return (width != 16'd0) && (height != 16'd0) &&
               (ch_groups != 16'd0) && (row_vectors <= max_vectors);
    endfunction

endpackage

// File: rtl/upsample2x_if.sv
// Valid/ready stream bundle for the upsampler: one input stream and one
// output stream. The slave side is the upsampler, the master side is the
// producer/consumer around it.
interface upsample2x_if #(
    parameter int VEC_W = yolo_stream_pkg::VEC_W
) ();

    logic [VEC_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/upsample2x_row_buffer_ram.sv
// Simple dual-port row buffer: synchronous write, registered read.
// Contents are intentionally not reset so the array maps onto block RAM.
module row_buffer_ram #(
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port with one cycle of registered latency.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/upsample2x.sv
// Nearest-neighbour 2x upsampler. One input row is captured into the row
// buffer, then replayed as two output rows with every pixel doubled. Reads
// are prefetched into a 2-entry output stage so the RAM latency is hidden.
module upsample2x #(
    parameter int MAX_ROW_VECTORS = 4096,
    parameter int VEC_W           = yolo_stream_pkg::VEC_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic [15:0] channels,
    upsample2x_if.slave strm,
    output logic        done,
    output logic        cfg_err
);

    import yolo_stream_pkg::up_state_e;
    import yolo_stream_pkg::IDLE;
    import yolo_stream_pkg::FILL;
    import yolo_stream_pkg::EMIT;
    import yolo_stream_pkg::FIN;
    import yolo_stream_pkg::cfg_is_valid;

    localparam int ADDR_W = (MAX_ROW_VECTORS > 1) ? $clog2(MAX_ROW_VECTORS) : 1;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(32'd1);
    localparam logic [31:0] MAX_V = 32'(MAX_ROW_VECTORS);

    // State and frame configuration
    up_state_e         state_q, state_d;
    logic [ADDR_W-1:0] w_m1_q, w_m1_d;
    logic [ADDR_W-1:0] chl_m1_q, chl_m1_d;
    logic [ADDR_W-1:0] vlast_q, vlast_d;
    logic [15:0]       h_m1_q, h_m1_d;
    logic [15:0]       in_row_q, in_row_d;

    // Fill and replay counters
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [ADDR_W-1:0] grp_q, grp_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] pix_base_q, pix_base_d;
    logic              rep_col_q, rep_col_d;
    logic              rep_row_q, rep_row_d;
    logic              issue_done_q, issue_done_d;

    // Prefetch / output stage
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [VEC_W-1:0]  head_q, head_d;
    logic [VEC_W-1:0]  tail_q, tail_d;
    logic              out_valid_q, out_valid_d;

    // Registered status outputs
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    // Combinational helpers
    logic [15:0]       chl_s;
    logic [31:0]       v_s;
    logic              cfg_ok_s;
    logic              we_s;
    logic              issue_s;
    logic              pop_s;
    logic              push_s;
    logic [2:0]        occ_s;
    logic              issue_ok_s;
    logic              last_pop_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [VEC_W-1:0]  rd_data_s;
    logic              unused_s;

    assign chl_s      = {3'b000, channels[15:3]};
    assign v_s        = {16'h0000, img_width} * {16'h0000, chl_s};
    assign cfg_ok_s   = cfg_is_valid(img_width, img_height, chl_s, v_s, MAX_V);
    assign unused_s   = ^channels[2:0];

    assign pop_s      = out_valid_q & strm.out_ready;
    assign push_s     = rd_pend_q;
    // Occupancy after this cycle's pop, counting the read still in flight;
    // a new read may only be issued if it is guaranteed a slot.
    assign occ_s      = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
    assign issue_ok_s = (occ_s <= 3'd1);
    assign last_pop_s = issue_done_q & ~rd_pend_q & pop_s & (cnt_q == 2'd1);
    assign rd_addr_s  = pix_base_q + grp_q;

    row_buffer_ram #(
        .DEPTH (MAX_ROW_VECTORS),
        .WIDTH (VEC_W),
        .ADDR_W(ADDR_W)
    ) u_row_buf (
        .clk      (clk),
        .wr_en_i  (we_s),
        .wr_addr_i(wr_q),
        .wr_data_i(strm.in_data),
        .rd_en_i  (issue_s),
        .rd_addr_i(rd_addr_s),
        .rd_data_o(rd_data_s)
    );

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = head_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;

    // Next-state, counter and output-stage logic.
    always_comb begin
        state_d      = state_q;
        w_m1_d       = w_m1_q;
        chl_m1_d     = chl_m1_q;
        vlast_d      = vlast_q;
        h_m1_d       = h_m1_q;
        in_row_d     = in_row_q;
        wr_d         = wr_q;
        grp_d        = grp_q;
        pix_d        = pix_q;
        pix_base_d   = pix_base_q;
        rep_col_d    = rep_col_q;
        rep_row_d    = rep_row_q;
        issue_done_d = issue_done_q;
        rd_pend_d    = 1'b0;
        cnt_d        = cnt_q;
        head_d       = head_q;
        tail_d       = tail_q;
        cfg_err_d    = cfg_err_q;
        we_s         = 1'b0;
        issue_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok_s) begin
                        state_d   = FILL;
                        w_m1_d    = ADDR_W'(img_width - 16'd1);
                        chl_m1_d  = ADDR_W'(chl_s - 16'd1);
                        vlast_d   = ADDR_W'(v_s - 32'd1);
                        h_m1_d    = img_height - 16'd1;
                        in_row_d  = 16'd0;
                        wr_d      = '0;
                        cfg_err_d = 1'b0;
                    end else begin
                        state_d   = FIN;
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            FILL: begin
                if (strm.in_valid && in_ready_q) begin
                    we_s = 1'b1;
                    if (wr_q == vlast_q) begin
                        wr_d         = '0;
                        state_d      = EMIT;
                        grp_d        = '0;
                        pix_d        = '0;
                        pix_base_d   = '0;
                        rep_col_d    = 1'b0;
                        rep_row_d    = 1'b0;
                        issue_done_d = 1'b0;
                    end else begin
                        wr_d = wr_q + A_ONE;
                    end
                end else begin
                    wr_d = wr_q;
                end
            end

            EMIT: begin
                if (!issue_done_q && issue_ok_s) begin
                    issue_s = 1'b1;
                    if (grp_q == chl_m1_q) begin
                        grp_d = '0;
                        if (rep_col_q) begin
                            rep_col_d = 1'b0;
                            if (pix_q == w_m1_q) begin
                                pix_d      = '0;
                                pix_base_d = '0;
                                if (rep_row_q) begin
                                    rep_row_d    = 1'b0;
                                    issue_done_d = 1'b1;
                                end else begin
                                    rep_row_d = 1'b1;
                                end
                            end else begin
                                pix_d      = pix_q + A_ONE;
                                pix_base_d = pix_base_q + chl_m1_q + A_ONE;
                            end
                        end else begin
                            rep_col_d = 1'b1;
                        end
                    end else begin
                        grp_d = grp_q + A_ONE;
                    end
                end else begin
                    issue_s = 1'b0;
                end

                if (last_pop_s) begin
                    if (in_row_q == h_m1_q) begin
                        state_d = FIN;
                    end else begin
                        in_row_d = in_row_q + 16'd1;
                        state_d  = FILL;
                    end
                end else begin
                    state_d = EMIT;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rd_pend_d = issue_s;

        case ({push_s, pop_s})
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = rd_data_s;
                end else begin
                    head_d = rd_data_s;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = rd_data_s;
                    cnt_d  = 2'd1;
                end else begin
                    tail_d = rd_data_s;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        out_valid_d = (cnt_d != 2'd0);
        in_ready_d  = (state_d == FILL);
        done_d      = (state_d == FIN);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame configuration and fill/replay counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_m1_q       <= '0;
            chl_m1_q     <= '0;
            vlast_q      <= '0;
            h_m1_q       <= 16'd0;
            in_row_q     <= 16'd0;
            wr_q         <= '0;
            grp_q        <= '0;
            pix_q        <= '0;
            pix_base_q   <= '0;
            rep_col_q    <= 1'b0;
            rep_row_q    <= 1'b0;
            issue_done_q <= 1'b0;
        end else begin
            w_m1_q       <= w_m1_d;
            chl_m1_q     <= chl_m1_d;
            vlast_q      <= vlast_d;
            h_m1_q       <= h_m1_d;
            in_row_q     <= in_row_d;
            wr_q         <= wr_d;
            grp_q        <= grp_d;
            pix_q        <= pix_d;
            pix_base_q   <= pix_base_d;
            rep_col_q    <= rep_col_d;
            rep_row_q    <= rep_row_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Prefetch stage and registered stream/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q   <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_upsample2x.sv
// Directed bench for upsample2x: scenarios run in sequence from one initial
// block, expected streams come from hand-written lists or a small
// nearest-neighbour reference loop.
module tb_upsample2x;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [15:0] channels;
    logic        done;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] stim[$];
    logic [63:0] expq[$];

    localparam logic [63:0] VA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VB = 64'hFEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    upsample2x_if s_if ();

    upsample2x #(
        .MAX_ROW_VECTORS(4096),
        .VEC_W          (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_width (img_width),
        .img_height(img_height),
        .channels  (channels),
        .strm      (s_if.slave),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] mk_vec(input int s, input int i);
        return {8'(s), 8'(i), 8'(3 * i + 1), 8'hA5, 8'(~i), 8'(s + i), 8'h3C, 8'(5 * i)};
    endfunction

    // Reference ordering: rows, each twice; pixels, each twice; groups inner.
    task automatic build_expect(input int w, input int h, input int ch);
        int chl = ch / 8;
        int v = w * chl;
        expq.delete();
        for (int r = 0; r < h; r++)
            for (int rr = 0; rr < 2; rr++)
                for (int p = 0; p < w; p++)
                    for (int rc = 0; rc < 2; rc++)
                        for (int g = 0; g < chl; g++)
                            expq.push_back(stim[r * v + p * chl + g]);
    endtask

    task automatic do_start(input int w, input int h, input int ch);
        @(negedge clk);
        img_width  = 16'(w);
        img_height = 16'(h);
        channels   = 16'(ch);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int ch, input bit rnd);
        int idx = 0, oidx = 0, cyc = 0, last_hs = -10, done_cyc = -1;
        int runlen = 0, runs = 0, bad_runs = 0, ir_in_emit = 0, stall_bad = 0;
        int total_in = w * h * (ch / 8);
        logic prev_stall = 1'b0;
        logic [63:0] prev_data = 64'd0;
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b0;
        do_start(w, h, ch);
        chk({tag, " in_ready_after_start"}, 64'(s_if.in_ready), 64'd1);
        chk({tag, " cfg_err_cleared"}, 64'(cfg_err), 64'd0);
        while (cyc < 20000) begin
            if (prev_stall && !(s_if.out_valid === 1'b1 && s_if.out_data === prev_data)) stall_bad++;
            if (s_if.out_valid === 1'b1 && s_if.in_ready !== 1'b0) ir_in_emit++;
            if (s_if.out_valid === 1'b1) runlen++;
            else if (runlen != 0) begin
                runs++;
                if (runlen != 4 * w * (ch / 8)) bad_runs++;
                runlen = 0;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            s_if.in_valid  = (idx < total_in) && (rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
            s_if.in_data   = (idx < total_in) ? stim[idx] : 64'd0;
            s_if.out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (s_if.in_valid && s_if.in_ready) idx++;
            prev_stall = s_if.out_valid && !s_if.out_ready;
            prev_data  = s_if.out_data;
            if (s_if.out_valid && s_if.out_ready) begin
                if (oidx < expq.size())
                    chk($sformatf("%s out[%0d]", tag, oidx), s_if.out_data, expq[oidx]);
                else
                    chk($sformatf("%s extra_out", tag), 64'(oidx), 64'(expq.size()));
                oidx++;
                last_hs = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        s_if.in_valid = 1'b0;
        chk({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({tag, " done_latency"}, 64'(done_cyc), 64'(last_hs + 1));
        chk({tag, " out_count"}, 64'(oidx), 64'(expq.size()));
        chk({tag, " in_count"}, 64'(idx), 64'(total_in));
        chk({tag, " in_ready_low_in_emit"}, 64'(ir_in_emit), 64'd0);
        chk({tag, " cfg_err_low"}, 64'(cfg_err), 64'd0);
        if (rnd) begin
            chk({tag, " stall_hold"}, 64'(stall_bad), 64'd0);
        end else begin
            chk({tag, " gapless_rows"}, 64'(runs), 64'(h));
            chk({tag, " row_run_len"}, 64'(bad_runs), 64'd0);
        end
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int fed, dn, ov;
        rst_n          = 1'b0;
        start          = 1'b0;
        img_width      = 16'd0;
        img_height     = 16'd0;
        channels       = 16'd0;
        s_if.in_valid  = 1'b0;
        s_if.in_data   = 64'd0;
        s_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 64'(s_if.in_ready), 64'd0);
        chk("rst out_valid", 64'(s_if.out_valid), 64'd0);
        chk("rst out_data", s_if.out_data, 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst cfg_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle in_ready", 64'(s_if.in_ready), 64'd0);

        // Single channel group: A B -> A A B B A A B B.
        stim = '{VA, VB};
        expq = '{VA, VA, VB, VB, VA, VA, VB, VB};
        run_frame("s1", 2, 1, 8, 1'b0);

        // Two channel groups, two rows.
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(mk_vec(2, i));
        build_expect(2, 2, 16);
        chk("s2 model out[2]", expq[2], stim[0]);
        chk("s2 model out[17]", expq[17], stim[5]);
        run_frame("s2", 2, 2, 16, 1'b0);

        // Same stream under random valid/ready.
        run_frame("s3", 2, 2, 16, 1'b1);

        // Sustained throughput: 64 outputs per input row.
        stim.delete();
        for (int i = 0; i < 48; i++) stim.push_back(mk_vec(4, i));
        build_expect(4, 3, 32);
        run_frame("s4", 4, 3, 32, 1'b0);

        // Oversized row: 129 x 32 groups = 4128 vectors.
        do_start(129, 1, 256);
        chk("bad cfg_err", 64'(cfg_err), 64'd1);
        chk("bad done", 64'(done), 64'd1);
        dn = 0;
        ov = 0;
        s_if.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (s_if.out_valid === 1'b1) ov++;
        end
        chk("bad done_single", 64'(dn), 64'd0);
        chk("bad no_out_valid", 64'(ov), 64'd0);
        chk("bad cfg_err_sticky", 64'(cfg_err), 64'd1);
        stim = '{VA, VB};
        expq = '{VA, VA, VB, VB, VA, VA, VB, VB};
        run_frame("after_bad", 2, 1, 8, 1'b0);

        // Reset in the middle of EMIT.
        do_start(2, 1, 8);
        s_if.out_ready = 1'b0;
        fed = 0;
        for (int c = 0; c < 50 && fed < 2; c++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = stim[fed];
            if (s_if.in_ready === 1'b1) fed++;
            @(negedge clk);
        end
        s_if.in_valid = 1'b0;
        for (int c = 0; c < 20 && s_if.out_valid !== 1'b1; c++) @(negedge clk);
        chk("mid out_valid_before_reset", 64'(s_if.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid out_valid_async", 64'(s_if.out_valid), 64'd0);
        chk("mid in_ready_async", 64'(s_if.in_ready), 64'd0);
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("mid no_done", 64'(dn), 64'd0);
        expq = '{VA, VA, VB, VB, VA, VA, VB, VB};
        run_frame("restart", 2, 1, 8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upsample2x.md
# upsample2x

Nearest-neighbour 2x upsampler for the TinyYOLOv3 feature-map stream (the upsample layer ahead of the second detection head). It is the inverse of the pooling path: it consumes one 64-bit vector per beat (8 signed int8 channels, ordered row → column → channel group) and emits each pixel twice horizontally and each row twice vertically. Input and output both use valid/ready handshakes. One input row is held in an on-chip row buffer so it can be replayed.

## Interface
Parameters:
- MAX_ROW_VECTORS, 4096: depth of the row buffer; the maximum img_width × channel groups.
- VEC_W, 64: vector width, 8 lanes × 8 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; samples the configuration when the block is IDLE.
- img_width  in  16  input width in pixels.
- img_height  in  16  input height in pixels.
- channels  in  16  channel count, a multiple of 8. ch_limit = channels >> 3.
- in_data  in  64  input vector.
- in_valid  in  1  input vector is valid.
- in_ready  out  1  block accepts an input vector.
- out_data  out  64  output vector.
- out_valid  out  1  output vector is valid.
- out_ready  in  1  downstream accepts the output vector.
- done  out  1  one-cycle pulse when the frame is complete.
- cfg_err  out  1  set when a bad configuration is sampled; sticky until the next start.

## Operation
- The configuration is registered at start: W, H, ch_limit, and V = W × ch_limit (32-bit product). It is held constant for the whole frame.
- The state machine has four states: IDLE, FILL, EMIT, FIN.
- IDLE:
  - If start arrives and W, H, ch_limit are all nonzero and V ≤ MAX_ROW_VECTORS, go to FILL with in_row = 0.
  - If start arrives and any of those checks fail, go to FIN, set cfg_err, and produce no output.
- FILL:
  - in_ready = 1.
  - Each input handshake writes in_data to buf[wr_addr], then wr_addr increments.
  - After V handshakes, go to EMIT.
- EMIT:
  - in_ready = 0.
  - Counters run from innermost to outermost: grp (0..ch_limit-1), rep_col (0..1), pix (0..W-1), rep_row (0..1).
  - Read address = pix_base + grp. pix_base advances by ch_limit on each pix increment, so no multiplier is needed.
  - Each output row is W × 2 × ch_limit vectors. Each input row produces 4V output vectors.
  - After the last handshake of rep_row = 1: if in_row = H-1, go to FIN; otherwise in_row increments and the machine goes to FILL.
- FIN: done = 1 for one cycle, then return to IDLE.
- start is ignored outside IDLE.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold.
- The output path is a prefetching 2-entry skid stage, so one-cycle RAM read latency never causes a bubble.
- Reset values: in_ready = 0, out_valid = 0, done = 0, cfg_err = 0, out_data = 0, state = IDLE, all counters 0.
- Row buffer contents are not reset.
- Reset during operation (rst_n low) aborts the frame immediately. No done pulse is produced. Any partial output is discarded downstream.

## Timing
- in_ready rises 1 cycle after start is accepted.
- In FILL, up to one input vector is accepted per cycle.
- The first out_valid occurs at most 2 cycles after the last FILL handshake.
- With out_ready held at 1, EMIT produces one output per cycle with no gaps across grp, rep_col, pix and rep_row boundaries.
- in_ready rises on the cycle after the final EMIT handshake of a row.
- done is asserted on the cycle after the final output handshake of the frame, or 1 cycle after a start that sets cfg_err.
- ch_limit = 1 is valid: each pixel is one vector emitted twice consecutively.
- W = 1 is valid: each output row is 2 × ch_limit vectors.

## Structure
- Shared package yolo_stream_pkg:
  - VEC_W and LANES = 8.
  - The upsample state enum (IDLE, FILL, EMIT, FIN).
  - The PAD_VALUE constant, 8'h80 per lane.
- Sub-module row_buffer_ram:
  - Simple dual-port RAM, MAX_ROW_VECTORS × 64 bits.
  - Synchronous write, 1-cycle registered read.
  - No reset.
  - Must infer BRAM.

## Test plan
- **Single channel group:** W=2, H=1, ch=8, inputs A, B → outputs A A B B A A B B; done 1 cycle after the last output; cfg_err = 0.
- **Two channel groups:** W=2, H=2, ch=16, row 0 inputs a0 a1 b0 b1 → 16 outputs per row, each output row being a0 a1 a0 a1 b0 b1 b0 b1 (twice); 32 outputs in total.
- **Backpressure:** same stimulus as the previous scenario with out_ready random at 50% and in_valid random at 50% → identical sequence; out_data is held stable on every stalled cycle.
- **Sustained throughput:** W=4, H=3, ch=32, out_ready = 1 → 64 consecutive out_valid cycles per input row with no gaps; in_ready = 0 throughout EMIT.
- **Bad configuration:** W=129, ch=256 (V = 4128 > 4096) → cfg_err = 1, done 1 cycle later, no out_valid. A following good start clears cfg_err.
- **Reset mid-EMIT:** pull rst_n low mid-EMIT → out_valid and in_ready are 0 in the same cycle (asynchronous reset); no done pulse. Restarting with the first scenario's stimulus reproduces its output exactly.
